niosii_memtest_master: RTL

NIOSII_MEMTEST_MASTER -- requirements
Module: niosii_memtest_master

---
 rtl/niosii_memtest_pkg.sv | 25 ++
 rtl/niosii_memtest_cmp.sv | 51 +++++
 rtl/niosii_memtest_master.sv | 130 +++++++++++++
 3 files changed

// File: rtl/niosii_memtest_pkg.sv
// Shared types, defaults and the test pattern
// for the on-chip memory test master.
package niosii_memtest_pkg;

   localparam int MT_ADDR_W = 13;
   localparam int MT_DEPTH  = 6250;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_WRITE = 3'd1,
      ST_READ  = 3'd2,
      ST_DRAIN = 3'd3,
      ST_DONE  = 3'd4
   } state_e;

   // Address mirrored into both half-words keeps
   // adjacent-word aliasing visible in readback.
   function automatic logic [31:0] pattern(
      input logic [31:0] seed,
      input logic [12:0] a
   );
      return seed ^ {3'b000, a, 3'b000, a};
   endfunction

endpackage

// File: rtl/niosii_memtest_cmp.sv
// Readback compare pipeline with saturating
// error counter and first-error address latch.
module niosii_memtest_cmp
   import niosii_memtest_pkg::*;
#(
   parameter int ADDR_W = MT_ADDR_W,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              clear,
   input  logic              issue,
   input  logic [ADDR_W-1:0] issue_addr,
   input  logic [31:0]       issue_data,
   input  logic [31:0]       rdata,
   output logic [CNT_W-1:0]  err_count,
   output logic [ADDR_W-1:0] first_err_addr
);

   logic              pend_q;
   logic [31:0]       exp_q;
   logic [ADDR_W-1:0] addr_q;
   logic              miss;

   assign miss = pend_q && (rdata != exp_q);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pend_q         <= 1'b0;
         exp_q          <= '0;
         addr_q         <= '0;
         err_count      <= '0;
         first_err_addr <= '0;
      end else if (clear) begin
         pend_q         <= 1'b0;
         err_count      <= '0;
         first_err_addr <= '0;
      end else begin
         pend_q <= issue;
         exp_q  <= issue_data;
         addr_q <= issue_addr;
         if (miss) begin
            if (err_count != '1)
               err_count <= err_count + CNT_W'(1);
            if (err_count == '0)
               first_err_addr <= addr_q;
         end
      end
   end

endmodule

// File: rtl/niosii_memtest_master.sv
// Avalon-MM master that writes a seeded pattern
// to on-chip memory, reads it back and checks it.
module niosii_memtest_master
   import niosii_memtest_pkg::*;
#(
   parameter int ADDR_W = MT_ADDR_W,
   parameter int DEPTH  = MT_DEPTH
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              start,
   input  logic [31:0]       seed,
   input  logic [ADDR_W-1:0] word_count,
   output logic              busy,
   output logic              done,
   output logic              pass,
   output logic [15:0]       err_count,
   output logic [ADDR_W-1:0] first_err_addr,
   output logic [ADDR_W-1:0] avm_address,
   output logic [3:0]        avm_byteenable,
   output logic              avm_chipselect,
   output logic              avm_write,
   output logic [31:0]       avm_writedata,
   input  logic [31:0]       avm_readdata
);

   localparam logic [ADDR_W-1:0] DEPTH_C = ADDR_W'(DEPTH);
   localparam logic [ADDR_W-1:0] ONE =
      {{(ADDR_W-1){1'b0}}, 1'b1};

   state_e            state;
   logic [31:0]       seed_q;
   logic [ADDR_W-1:0] last_q;
   logic              fin_q;
   logic [ADDR_W-1:0] n_clamp;
   logic              accept;
   logic              at_last;
   logic [ADDR_W-1:0] addr_nx;

   assign n_clamp = (word_count > DEPTH_C) ? DEPTH_C : word_count;
   assign accept  = (state == ST_IDLE) && start;
   assign at_last = (avm_address == last_q);
   assign addr_nx = avm_address + ONE;

   assign busy = (state != ST_IDLE);
   assign done = (state == ST_DONE);
   assign pass = fin_q && (err_count == '0);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state          <= ST_IDLE;
         seed_q         <= '0;
         last_q         <= '0;
         fin_q          <= 1'b0;
         avm_address    <= '0;
         avm_byteenable <= 4'h0;
         avm_chipselect <= 1'b0;
         avm_write      <= 1'b0;
         avm_writedata  <= '0;
      end else begin
         unique case (state)
            ST_IDLE: begin
               if (start) begin
                  seed_q <= seed;
                  last_q <= n_clamp - ONE;
                  fin_q  <= (n_clamp == '0);
                  if (n_clamp != '0) begin
                     state          <= ST_WRITE;
                     avm_address    <= '0;
                     avm_byteenable <= 4'hF;
                     avm_chipselect <= 1'b1;
                     avm_write      <= 1'b1;
                     avm_writedata  <= pattern(seed, 13'd0);
                  end else begin
                     state <= ST_DONE;
                  end
               end
            end
            ST_WRITE: begin
               if (at_last) begin
                  state       <= ST_READ;
                  avm_address <= '0;
                  avm_write   <= 1'b0;
               end else begin
                  avm_address   <= addr_nx;
                  avm_writedata <= pattern(seed_q, 13'(addr_nx));
               end
            end
            ST_READ: begin
               if (at_last) begin
                  state          <= ST_DRAIN;
                  avm_address    <= '0;
                  avm_byteenable <= 4'h0;
                  avm_chipselect <= 1'b0;
               end else begin
                  avm_address <= addr_nx;
               end
            end
            ST_DRAIN: begin
               state <= ST_DONE;
               fin_q <= 1'b1;
            end
            ST_DONE: begin
               state <= ST_IDLE;
            end
            default: begin
               state          <= ST_IDLE;
               avm_chipselect <= 1'b0;
               avm_write      <= 1'b0;
            end
         endcase
      end
   end

   niosii_memtest_cmp #(
      .ADDR_W (ADDR_W),
      .CNT_W  (16)
   ) u_cmp (
      .clk            (clk),
      .reset_n        (reset_n),
      .clear          (accept),
      .issue          (state == ST_READ),
      .issue_addr     (avm_address),
      .issue_data     (pattern(seed_q, 13'(avm_address))),
      .rdata          (avm_readdata),
      .err_count      (err_count),
      .first_err_addr (first_err_addr)
   );

endmodule
